// File: rtl/ppg_acc_pkg.sv
// -----------------------------------------------------------------------------
// ppg_acc_pkg
// Shared constants for the Booth partial-product tap accumulator.
//   PP0_W / PPN_W : widths of partial product 0 and partial products 1..3.
//   PP_BIAS       : sign-extension bias each uncorrected PPG product carries.
//   corr_const()  : correction that removes the bias of a whole window,
//                   i.e. -(taps * PP_BIAS) reduced mod 2^acc_w.
// -----------------------------------------------------------------------------
package ppg_acc_pkg;

    localparam int PP0_W = 11;
    localparam int PPN_W = 9;

    localparam int unsigned PP_BIAS = 32'd22528;

    function automatic logic [31:0] corr_const(input int unsigned taps,
                                               input int unsigned acc_w);
        logic [31:0] mask;
        mask = (acc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << acc_w) - 32'd1);
        return (32'd0 - taps * PP_BIAS) & mask;
    endfunction

endpackage

// File: rtl/ppg_reduce.sv
// -----------------------------------------------------------------------------
// ppg_reduce
// Combinational weighted sum of one Booth PPG output set into a single biased
// product (the bias is removed later, once per window).
//   pp0_i       [PP0_W] : partial product 0, weight 1
//   pp1_i..pp3_i[PPN_W] : partial products 1..3, weights 4, 16, 64
//   neg0_i..neg3_i      : two's-complement completion bits, same weights
//   sum_o       [ACC_W] : zero-extended weighted sum
// -----------------------------------------------------------------------------
module ppg_reduce
    import ppg_acc_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic [PP0_W-1:0] pp0_i,
    input  logic [PPN_W-1:0] pp1_i,
    input  logic [PPN_W-1:0] pp2_i,
    input  logic [PPN_W-1:0] pp3_i,
    input  logic             neg0_i,
    input  logic             neg1_i,
    input  logic             neg2_i,
    input  logic             neg3_i,
    output logic [ACC_W-1:0] sum_o
);

    always_comb begin
        sum_o = ACC_W'(pp0_i)
              + (ACC_W'(pp1_i) << 2)
              + (ACC_W'(pp2_i) << 4)
              + (ACC_W'(pp3_i) << 6)
              + ACC_W'(neg0_i)
              + (ACC_W'(neg1_i) << 2)
              + (ACC_W'(neg2_i) << 4)
              + (ACC_W'(neg3_i) << 6);
    end

endmodule

// File: rtl/ppg_tap_accumulator.sv
// -----------------------------------------------------------------------------
// ppg_tap_accumulator
// Accepts one Booth PPG output set per beat, accumulates KERNEL_TAPS biased
// products and emits one bias-corrected signed dot product per window.
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   clear             : abort the current window (pending result is kept)
//   in_valid/in_ready : PPG set handshake
//   pp0..pp3, neg0..3 : Booth partial products and negate bits
//   out_valid/out_ready/out_data : result handshake, ACC_W-bit wrapping sum
//   tap_idx           : index of the next tap to be accepted
// Two stages: stage 1 registers the reduced product and a last-tap flag,
// stage 2 accumulates and, on the last tap, writes the corrected result.
// -----------------------------------------------------------------------------
module ppg_tap_accumulator
    import ppg_acc_pkg::*;
#(
    parameter int KERNEL_TAPS = 9,
    parameter int ACC_W       = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP0_W-1:0] pp0,
    input  logic [PPN_W-1:0] pp1,
    input  logic [PPN_W-1:0] pp2,
    input  logic [PPN_W-1:0] pp3,
    input  logic             neg0,
    input  logic             neg1,
    input  logic             neg2,
    input  logic             neg3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [3:0]       tap_idx
);

    localparam logic [ACC_W-1:0] CORR     = ACC_W'(corr_const(KERNEL_TAPS, ACC_W));
    localparam logic [3:0]       LAST_TAP = 4'(KERNEL_TAPS - 1);

    logic [ACC_W-1:0] raw_prod;
    logic [ACC_W-1:0] window_sum;
    logic             adv;

    logic [ACC_W-1:0] prod_q,      prod_d;
    logic             last_q,      last_d;
    logic             s1_valid_q,  s1_valid_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [3:0]       tap_q,       tap_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;

    ppg_reduce #(.ACC_W(ACC_W)) u_reduce (
        .pp0_i  (pp0),
        .pp1_i  (pp1),
        .pp2_i  (pp2),
        .pp3_i  (pp3),
        .neg0_i (neg0),
        .neg1_i (neg1),
        .neg2_i (neg2),
        .neg3_i (neg3),
        .sum_o  (raw_prod)
    );

    // The whole pipeline moves only when the output slot is free or draining.
    assign adv        = !out_valid_q || out_ready;
    assign window_sum = acc_q + prod_q;

    always_comb begin
        // NOTE: every next-state value defaults to hold, so no path leaves a
        // variable unassigned and no latch is inferred.
        prod_d      = prod_q;
        last_d      = last_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (adv) begin
            // adv with out_valid set means out_ready is high: result consumed.
            if (out_valid_q) begin
                out_valid_d = 1'b0;
            end

            if (clear) begin
                // Drop the in-flight product and the beat offered this cycle.
                acc_d      = '0;
                tap_d      = '0;
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    prod_d = raw_prod;
                    last_d = (tap_q == LAST_TAP);
                    tap_d  = (tap_q == LAST_TAP) ? 4'd0 : tap_q + 4'd1;
                end

                if (s1_valid_q) begin
                    if (last_q) begin
                        // Bias of all taps is removed once, here.
                        out_data_d  = window_sum + CORR;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                    end else begin
                        acc_d = window_sum;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            prod_q      <= '0;
            last_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign tap_idx   = tap_q;

endmodule

// File: tb/tb_ppg_tap_accumulator.sv
// -----------------------------------------------------------------------------
// tb_ppg_tap_accumulator
// Directed bench for ppg_tap_accumulator (9 taps, 19-bit accumulator).
// A small radix-4 Booth PPG model turns (a, b) int8 pairs into the partial
// product sets the block expects; every expected result is a hand-computed
// window sum.
// -----------------------------------------------------------------------------
module tb_ppg_tap_accumulator;

    localparam int ACC_W = 19;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      pp0;
    logic [8:0]       pp1;
    logic [8:0]       pp2;
    logic [8:0]       pp3;
    logic             neg0;
    logic             neg1;
    logic             neg2;
    logic             neg3;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [3:0]       tap_idx;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] res_q [$];

    int mix_a [9] = '{1, -3, 5, 127, -1, 0, 7, -128, 10};
    int mix_b [9] = '{2, 4, -6, 127, -1, 99, 7, 1, -10};

    always #5 clk = ~clk;

    ppg_tap_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .neg0      (neg0),
        .neg1      (neg1),
        .neg2      (neg2),
        .neg3      (neg3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tap_idx   (tap_idx)
    );

    // Record every completed output handshake (inputs are stable at negedge).
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) res_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Radix-4 Booth PPG with sign-extension-free encoding:
    // pp0 = {~s, s, s, x[7:0]}, ppN = {~s, x[7:0]}; raw sum = a*b + 22528.
    task automatic booth_ppg(input logic signed [7:0] av, input logic [7:0] bv,
                             output logic [10:0] p0, output logic [8:0] p1,
                             output logic [8:0] p2, output logic [8:0] p3,
                             output logic [3:0] n);
        logic [8:0] bx;
        logic [8:0] x [4];
        bx = {bv, 1'b0};
        n  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            int d;
            int mag;
            d   = (bx[2*i+1] ? 1 : 0) + (bx[2*i] ? 1 : 0) - (bx[2*i+2] ? 2 : 0);
            mag = (d < 0 ? -d : d) * int'(av);
            x[i] = mag[8:0];
            if (d < 0) begin
                x[i] = ~x[i];
                n[i] = 1'b1;
            end
        end
        p0 = {~x[0][8], x[0][8], x[0][8], x[0][7:0]};
        p1 = {~x[1][8], x[1][7:0]};
        p2 = {~x[2][8], x[2][7:0]};
        p3 = {~x[3][8], x[3][7:0]};
    endtask

    task automatic present(input int a, input int b);
        logic signed [7:0] av;
        logic [7:0]        bv;
        logic [10:0]       p0;
        logic [8:0]        p1, p2, p3;
        logic [3:0]        n;
        av = a[7:0];
        bv = b[7:0];
        booth_ppg(av, bv, p0, p1, p2, p3, n);
        pp0  = p0;
        pp1  = p1;
        pp2  = p2;
        pp3  = p3;
        neg0 = n[0];
        neg1 = n[1];
        neg2 = n[2];
        neg3 = n[3];
        in_valid = 1'b1;
    endtask

    // Offer one set and hold it until the block takes it (bounded).
    task automatic send(input int a, input int b, input string tag);
        int waited = 0;
        present(a, b);
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic send_window(input int a, input int b, input string tag);
        for (int i = 0; i < 9; i++) send(a, b, tag);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp);
        int n = 0;
        logic [ACC_W-1:0] got;
        while (res_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_present"}, 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
            got = res_q.pop_front();
            check(tag, 32'(got), exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0;
        neg0 = 1'b0; neg1 = 1'b0; neg2 = 1'b0; neg3 = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_tap_idx",   32'(tap_idx),   32'd0);
        reset = 1'b1;
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Single window 3*5, with tap index and latency checks
        for (int i = 0; i < 4; i++) send(3, 5, "w1");
        check("w1_tap_idx_mid", 32'(tap_idx), 32'd4);
        for (int i = 0; i < 5; i++) send(3, 5, "w1");
        idle();
        check("w1_tap_idx_wrap",  32'(tap_idx),   32'd0);
        check("w1_lat1_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("w1_lat2_valid",    32'(out_valid), 32'd1);
        check("w1_data",          32'(out_data),  32'd135);
        expect_result("w1_result", 32'd135);
        check("w1_valid_drop",    32'(out_valid), 32'd0);

        // Back-to-back extreme windows, no bubble
        send_window(-128, -128, "w2");
        send_window(-128, 127, "w3");
        idle();
        expect_result("w2_neg_neg", 32'h24000);
        expect_result("w3_neg_pos", 32'h5C480);

        // Mixed operands within one window: sum of products = 15911
        for (int i = 0; i < 9; i++) send(mix_a[i], mix_b[i], "w4");
        idle();
        expect_result("w4_mixed", 32'h03E27);

        // Backpressure: result A stalls while window B is in flight
        out_ready = 1'b0;
        send_window(4, 4, "bpA");
        send(2, -3, "bpB");
        present(2, -3);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'd144);
            check("bp_tap_idx",   32'(tap_idx),   32'd1);
            tick();
        end
        check("bp_no_transfer", 32'(res_q.size()), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(2, -3, "bpB");
        idle();
        expect_result("bp_resA", 32'd144);
        expect_result("bp_resB", 32'h7FFCA);

        // clear after tap 4 drops the partial window and the beat offered
        for (int i = 0; i < 4; i++) send(5, 5, "clr");
        present(50, 50);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        check("clr_tap_idx", 32'(tap_idx), 32'd0);
        tick();
        tick();
        check("clr_no_result", 32'(res_q.size()), 32'd0);
        send_window(1, 1, "clr_win");
        idle();
        expect_result("clr_result", 32'd9);

        // reset mid-window at tap 6
        for (int i = 0; i < 6; i++) send(7, 7, "mrst");
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mrst_tap_idx",   32'(tap_idx),   32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data",  32'(out_data),  32'd0);
        tick();
        tick();
        check("mrst_no_spurious", 32'(res_q.size()), 32'd0);
        send_window(-5, 11, "mrst_win");
        idle();
        expect_result("mrst_result", 32'h7FE11);
        for (int i = 0; i < 4; i++) tick();
        check("mrst_single_result", 32'(res_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
